keypad_debounce: RTL and testbench
==================================

# keypad_debounce

Debounce-and-capture stage downstream of the keypad row scanner and upstream of the two-digit seven-segment display. Paces the scanner with a row-advance pulse, samples the synchronized column lines against the driven row, debounces each press and release, and on every accepted press shifts a two-entry key history (`s0` most recent, `s1` previous). The display multiplexer reads `s0`/`s1` directly.

## Interface
- `SCAN_DIV`, 4000: cycles each row is held before sampling (100 µs at 40 MHz); minimum 4.
- `DEBOUNCE_CYCLES`, 200000: consecutive stable cycles required to accept a press or release (5 ms at 40 MHz); minimum 2.
- `clk`  in  1  system clock (40 MHz).
- `reset`  in  1  synchronous, active-high reset.
- `row`  in  4  row currently driven by the scanner, one-hot; bit r = row r.
- `col`  in  4  raw asynchronous keypad columns, active-high; bit c = column c.
- `scan_adv`  out  1  single-cycle pulse; the scanner advances to the next row on it.
- `s0`  out  4  most recently accepted key code.
- `s1`  out  4  key code accepted before `s0`.
- `key_strobe`  out  1  single-cycle pulse in the cycle `s0`/`s1` update.

## Operation
- `col` passes through a 2-flop synchronizer (`col_sync`, reset 0) before any use.
- One shared counter `cnt`, at least 18 bits, holds `SCAN_DIV` and `DEBOUNCE_CYCLES` values; it resets to 0 on every state change.
- Key map, row r / column c:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- When several columns are set, the lowest set column wins.
- States:
  - IDLE: `cnt` counts 0..SCAN_DIV-1. At SCAN_DIV-1, if `row` is one-hot and `col_sync` != 0, latch `key_row` = `row` and `key_col` = lowest set column index, then go to DB_PRESS. Otherwise pulse `scan_adv` and restart the count. A non-one-hot `row` counts as no press.
  - DB_PRESS: no `scan_adv`, so the scanner holds the row. If `col_sync[key_col]` = 0, return to IDLE with no strobe (bounce). Otherwise count; at DEBOUNCE_CYCLES-1 go to HELD, load `s1` <= `s0` and `s0` <= decoded key, and pulse `key_strobe`.
  - HELD: if `col_sync[key_col]` = 0, go to DB_RELEASE. Presses on other columns are ignored.
  - DB_RELEASE: if `col_sync[key_col]` = 1, return to HELD with no new strobe. Otherwise count; at DEBOUNCE_CYCLES-1 go to IDLE and pulse `scan_adv`.
- Holding one key produces exactly one strobe, however long it is held or however much it bounces.
- A second key still down after the first is released is detected on a later IDLE sample of its row and produces its own strobe.
- A repeated key (same code twice) still shifts the history.

## Timing
- Reset values: state IDLE, `cnt` = 0, synchronizer = 0, `s0` = `s1` = 0, `key_strobe` = 0, `scan_adv` = 0.
- Reset mid-debounce aborts with no strobe and clears the history.
- All outputs are registered; `scan_adv` and `key_strobe` are high for exactly one cycle.
- Synchronizer latency is 2 cycles. Because `SCAN_DIV` ≥ 4, the IDLE sample reflects the current row.
- Press latency, from the first stable synchronized cycle of the key's row sample to `key_strobe`: `DEBOUNCE_CYCLES` + 1 cycles.
- `scan_adv` never pulses outside IDLE except the single pulse on the DB_RELEASE→IDLE transition.

## Test plan
Bench parameters: SCAN_DIV = 4, DEBOUNCE_CYCLES = 8.
- Reset: hold `reset` 3 cycles with `col` = 4'b1111, then release with `col` = 0 → `s0` = `s1` = 0, no strobe; the first `scan_adv` follows 4 cycles after reset deasserts, then one every 4 cycles.
- Clean press: scanner on `row` = 4'b0010; assert `col` = 4'b0100 for 40 cycles, then release → one `key_strobe`, `s0` = 6, `s1` = 0; `scan_adv` absent from the IDLE sample through release debounce.
- Bounce rejected: on `row` = 4'b0001, pulse `col[0]` for 3 cycles, low for 2, high for 3 → no strobe; FSM returns to IDLE and `scan_adv` resumes.
- Release bounce: hold key 9 (`row` = 4'b0100, `col` = 4'b0100) until accepted, then toggle `col[2]` low 3 / high 3 twice before a clean release → exactly one strobe with `s0` = 9.
- History shift: accept 1, then A, then 0 → after the third strobe, `s0` = 0 and `s1` = A.
- Multi-column priority and mid-debounce reset: on `row` = 4'b1000, `col` = 4'b1010 → accepted code 0 (column 1). Repeat, asserting `reset` at debounce cycle 5 → no strobe, history = 0.

Source files
------------

// File: rtl/keypad_debounce.sv
// Keypad debounce-and-capture stage: paces the row scanner, samples the
// synchronized columns, debounces press/release and keeps a two-key history.
module keypad_debounce #(
  parameter int SCAN_DIV        = 4000,
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic       scan_adv,
  output logic [3:0] s0,
  output logic [3:0] s1,
  output logic       key_strobe
);

  localparam int MAX_CNT = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CNT) > 18) ? $clog2(MAX_CNT) : 18;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       col_meta_q, col_sync_q;
  logic [1:0]       key_row_q, key_row_d;
  logic [1:0]       key_col_q, key_col_d;
  logic [3:0]       s0_q, s0_d;
  logic [3:0]       s1_q, s1_d;
  logic             strobe_q, strobe_d;
  logic             adv_q, adv_d;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Lowest set bit wins when several columns are active.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic [3:0] decode_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer for the asynchronous column lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_meta_q <= 4'd0;
      col_sync_q <= 4'd0;
    end else begin
      col_meta_q <= col;
      col_sync_q <= col_meta_q;
    end
  end

  // Control state, shared counter, history and registered pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      s0_q     <= 4'd0;
      s1_q     <= 4'd0;
      strobe_q <= 1'b0;
      adv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      strobe_q <= strobe_d;
      adv_q    <= adv_d;
    end
  end

  // Latched key position; only meaningful outside IDLE, so no reset needed.
  always_ff @(posedge clk) begin
    key_row_q <= key_row_d;
    key_col_q <= key_col_d;
  end

  // Next-state logic: scan pacing, press/release debounce, history shift.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_row_d = key_row_q;
    key_col_d = key_col_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    strobe_d  = 1'b0;
    adv_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (is_onehot(row) && (col_sync_q != 4'd0)) begin
            key_row_d = low_index(row);
            key_col_d = low_index(col_sync_q);
            state_d   = DB_PRESS;
          end else begin
            adv_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DB_PRESS: begin
        if (!col_sync_q[key_col_q]) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d  = HELD;
          cnt_d    = '0;
          s1_d     = s0_q;
          s0_d     = decode_key(key_row_q, key_col_q);
          strobe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!col_sync_q[key_col_q]) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end
      end
      DB_RELEASE: begin
        if (col_sync_q[key_col_q]) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          adv_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign scan_adv   = adv_q;
  assign key_strobe = strobe_q;
  assign s0         = s0_q;
  assign s1         = s1_q;

endmodule

// File: tb/tb_keypad_debounce.sv
// Directed bench for keypad_debounce with SCAN_DIV = 4, DEBOUNCE_CYCLES = 8.
module tb_keypad_debounce;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row = 4'b0001;
  logic [3:0] col = 4'b1111;
  logic       scan_adv;
  logic [3:0] s0;
  logic [3:0] s1;
  logic       key_strobe;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int adv_cnt = 0;

  keypad_debounce #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .scan_adv(scan_adv), .s0(s0), .s1(s1), .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;

  // Running pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (key_strobe) strobe_cnt <= strobe_cnt + 1;
    if (scan_adv)   adv_cnt    <= adv_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Wait (bounded) for a scan_adv; on return the IDLE counter is at 0.
  task automatic align_adv();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (scan_adv) seen = 1;
    end
  endtask

  // Press a key aligned to a scan_adv, hold it, release it; report the cycle of the
  // strobe after the press and of the scan_adv after the release (-1 if never seen).
  task automatic press_key(input logic [3:0] r, input logic [3:0] c,
                           output int lat, output int rel);
    align_adv();
    row = r;
    col = c;
    lat = -1;
    rel = -1;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      tick();
      if (key_strobe) lat = k;
    end
    repeat (4) tick();
    col = 4'd0;
    for (int k = 1; k <= 30 && rel < 0; k++) begin
      tick();
      if (scan_adv) rel = k;
    end
  endtask

  task automatic test_reset();
    int first;
    reset = 1'b1; col = 4'b1111; row = 4'b0001;
    repeat (3) tick();
    checks++; if (s0 !== 4'd0) begin errors++; $display("FAIL reset_s0: got %0d expected 0", s0); end
    checks++; if (s1 !== 4'd0) begin errors++; $display("FAIL reset_s1: got %0d expected 0", s1); end
    checks++; if (key_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", key_strobe); end
    checks++; if (scan_adv !== 1'b0) begin errors++; $display("FAIL reset_adv: got %b expected 0", scan_adv); end
    reset = 1'b0; col = 4'd0;
    for (int p = 0; p < 3; p++) begin
      first = -1;
      for (int k = 1; k <= 20 && first < 0; k++) begin
        tick();
        if (scan_adv) first = k;
      end
      checks++; if (first !== 4) begin errors++; $display("FAIL reset_adv_period%0d: got %0d cycles expected 4", p, first); end
    end
  endtask

  task automatic test_clean_press();
    int lat, rel, a0, sc;
    align_adv();
    row = 4'b0010; col = 4'b0100;
    a0 = adv_cnt; sc = strobe_cnt; lat = -1; rel = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (key_strobe && lat < 0) lat = k;
    end
    checks++; if (lat !== 12) begin errors++; $display("FAIL clean_latency: got %0d expected 12", lat); end
    checks++; if (adv_cnt !== a0) begin errors++; $display("FAIL clean_no_adv: got %0d pulses expected 0", adv_cnt - a0); end
    checks++; if (strobe_cnt !== sc + 1) begin errors++; $display("FAIL clean_strobes: got %0d expected 1", strobe_cnt - sc); end
    checks++; if (s0 !== 4'd6) begin errors++; $display("FAIL clean_s0: got %0d expected 6", s0); end
    checks++; if (s1 !== 4'd0) begin errors++; $display("FAIL clean_s1: got %0d expected 0", s1); end
    col = 4'd0;
    for (int k = 1; k <= 30 && rel < 0; k++) begin
      tick();
      if (scan_adv) rel = k;
    end
    checks++; if (rel !== 11) begin errors++; $display("FAIL clean_release_adv: got %0d expected 11", rel); end
    checks++; if (strobe_cnt !== sc + 1) begin errors++; $display("FAIL clean_release_strobes: got %0d expected 1", strobe_cnt - sc); end
  endtask

  task automatic test_bounce();
    int n, a0, sc;
    align_adv();
    row = 4'b0001;
    a0 = adv_cnt; sc = strobe_cnt; n = -1;
    col = 4'b0001; repeat (3) tick();
    col = 4'b0000; repeat (2) tick();
    col = 4'b0001; repeat (3) tick();
    col = 4'b0000;
    checks++; if (adv_cnt !== a0) begin errors++; $display("FAIL bounce_adv_held: got %0d pulses expected 0", adv_cnt - a0); end
    for (int k = 9; k <= 30 && n < 0; k++) begin
      tick();
      if (scan_adv) n = k;
    end
    checks++; if (n !== 15) begin errors++; $display("FAIL bounce_adv_resume: got cycle %0d expected 15", n); end
    checks++; if (strobe_cnt !== sc) begin errors++; $display("FAIL bounce_strobes: got %0d expected 0", strobe_cnt - sc); end
  endtask

  task automatic test_release_bounce();
    int lat, rel, sc;
    align_adv();
    row = 4'b0100; col = 4'b0100;
    sc = strobe_cnt; lat = -1; rel = -1;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      tick();
      if (key_strobe) lat = k;
    end
    repeat (3) tick();
    for (int t = 0; t < 2; t++) begin
      col = 4'b0000; repeat (3) tick();
      col = 4'b0100; repeat (3) tick();
    end
    col = 4'b0000;
    for (int k = 1; k <= 30 && rel < 0; k++) begin
      tick();
      if (scan_adv) rel = k;
    end
    checks++; if (lat !== 12) begin errors++; $display("FAIL relb_latency: got %0d expected 12", lat); end
    checks++; if (strobe_cnt !== sc + 1) begin errors++; $display("FAIL relb_strobes: got %0d expected 1", strobe_cnt - sc); end
    checks++; if (s0 !== 4'd9) begin errors++; $display("FAIL relb_s0: got %0d expected 9", s0); end
    checks++; if (s1 !== 4'd6) begin errors++; $display("FAIL relb_s1: got %0d expected 6", s1); end
    checks++; if (rel !== 11) begin errors++; $display("FAIL relb_release_adv: got %0d expected 11", rel); end
  endtask

  task automatic test_multi_column();
    int lat, rel;
    press_key(4'b1000, 4'b1010, lat, rel);
    checks++; if (lat !== 12) begin errors++; $display("FAIL multi_latency: got %0d expected 12", lat); end
    checks++; if (s0 !== 4'd0) begin errors++; $display("FAIL multi_s0: got %0d expected 0", s0); end
    checks++; if (s1 !== 4'd9) begin errors++; $display("FAIL multi_s1: got %0d expected 9", s1); end
    checks++; if (rel !== 11) begin errors++; $display("FAIL multi_release_adv: got %0d expected 11", rel); end
  endtask

  task automatic test_history();
    int lat, rel;
    press_key(4'b0001, 4'b0001, lat, rel);
    checks++; if (lat !== 12) begin errors++; $display("FAIL hist1_latency: got %0d expected 12", lat); end
    checks++; if (s0 !== 4'd1) begin errors++; $display("FAIL hist1_s0: got %0d expected 1", s0); end
    checks++; if (s1 !== 4'd0) begin errors++; $display("FAIL hist1_s1: got %0d expected 0", s1); end
    press_key(4'b0001, 4'b1000, lat, rel);
    checks++; if (s0 !== 4'hA) begin errors++; $display("FAIL hist2_s0: got %0d expected 10", s0); end
    checks++; if (s1 !== 4'd1) begin errors++; $display("FAIL hist2_s1: got %0d expected 1", s1); end
    press_key(4'b1000, 4'b0010, lat, rel);
    checks++; if (s0 !== 4'd0) begin errors++; $display("FAIL hist3_s0: got %0d expected 0", s0); end
    checks++; if (s1 !== 4'hA) begin errors++; $display("FAIL hist3_s1: got %0d expected 10", s1); end
    checks++; if (rel !== 11) begin errors++; $display("FAIL hist3_release_adv: got %0d expected 11", rel); end
  endtask

  task automatic test_reset_mid_debounce();
    int sc;
    align_adv();
    row = 4'b1000; col = 4'b1010;
    sc = strobe_cnt;
    repeat (9) tick();
    reset = 1'b1; col = 4'd0;
    repeat (2) tick();
    checks++; if (key_strobe !== 1'b0) begin errors++; $display("FAIL midrst_strobe: got %b expected 0", key_strobe); end
    reset = 1'b0;
    repeat (20) tick();
    checks++; if (strobe_cnt !== sc) begin errors++; $display("FAIL midrst_strobes: got %0d expected 0", strobe_cnt - sc); end
    checks++; if (s0 !== 4'd0) begin errors++; $display("FAIL midrst_s0: got %0d expected 0", s0); end
    checks++; if (s1 !== 4'd0) begin errors++; $display("FAIL midrst_s1: got %0d expected 0", s1); end
  endtask

  task automatic test_repeat_key();
    int lat, rel;
    press_key(4'b0010, 4'b0010, lat, rel);
    checks++; if (s0 !== 4'd5) begin errors++; $display("FAIL rep1_s0: got %0d expected 5", s0); end
    checks++; if (s1 !== 4'd0) begin errors++; $display("FAIL rep1_s1: got %0d expected 0", s1); end
    press_key(4'b0010, 4'b0010, lat, rel);
    checks++; if (lat !== 12) begin errors++; $display("FAIL rep2_latency: got %0d expected 12", lat); end
    checks++; if (s0 !== 4'd5) begin errors++; $display("FAIL rep2_s0: got %0d expected 5", s0); end
    checks++; if (s1 !== 4'd5) begin errors++; $display("FAIL rep2_s1: got %0d expected 5", s1); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_multi_column();
    test_history();
    test_reset_mid_debounce();
    test_repeat_key();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
